// File: rtl/ppu_palette_arbiter_if.sv
// Bus bundle between the palette arbiter, its requesters (render, CPU $2007 path) and the palette RAM.
interface ppu_palette_arbiter_if;
  logic       rend_req;
  logic [4:0] rend_idx;
  logic       rend_valid;
  logic [5:0] rend_color;
  logic       rend_hold;
  logic       cpu_req;
  logic       cpu_we;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_busy;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic [4:0] pal_addr;
  logic [7:0] palette_data_in;
  logic       palette_mem_rw;
  logic       palette_mem_en;
  logic [7:0] color_out;

  modport slave (
    input  rend_req, rend_idx, cpu_req, cpu_we, cpu_addr, cpu_wdata, color_out,
    output rend_valid, rend_color, rend_hold, cpu_busy, cpu_ack, cpu_rdata,
           pal_addr, palette_data_in, palette_mem_rw, palette_mem_en
  );

  modport master (
    output rend_req, rend_idx, cpu_req, cpu_we, cpu_addr, cpu_wdata, color_out,
    input  rend_valid, rend_color, rend_hold, cpu_busy, cpu_ack, cpu_rdata,
           pal_addr, palette_data_in, palette_mem_rw, palette_mem_en
  );
endinterface

// File: rtl/ppu_palette_arbiter.sv
// Shares the single palette RAM port between render (priority) and the CPU $2007 path,
// forcing a CPU slot after MAX_WAIT deferred cycles.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | no CPU access pending; render owns the port when it asks
//  ST_WAIT  | CPU access pending; served in the first cycle render is idle
//  ST_FORCE | CPU access pending and starved; served this cycle regardless
module ppu_palette_arbiter #(
  parameter int MAX_WAIT = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  ppu_palette_arbiter_if.slave   bus
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FORCE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             pend_we;
  logic [4:0]       pend_addr;
  logic [7:0]       pend_wdata;
  logic [5:0]       last_color;
  logic             cpu_accept;
  logic             cpu_drive;
  logic             rend_own;

  assign cpu_accept = bus.cpu_req & ~bus.cpu_busy;

  always_comb begin
    state_nxt           = state;
    wait_cnt_nxt        = wait_cnt;
    cpu_drive           = 1'b0;
    rend_own            = 1'b0;
    bus.palette_mem_en  = 1'b0;
    bus.palette_mem_rw  = 1'b0;
    bus.pal_addr        = '0;
    bus.palette_data_in = '0;

    case (state)
      ST_IDLE: begin
        rend_own = bus.rend_req;
        if (cpu_accept) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.rend_req) begin
          rend_own = 1'b1;
          if (wait_cnt != CNT_W'(MAX_WAIT)) wait_cnt_nxt = wait_cnt + CNT_W'(1);
          if (wait_cnt >= CNT_W'(MAX_WAIT - 1)) state_nxt = ST_FORCE;
        end else begin
          cpu_drive    = 1'b1;
          state_nxt    = ST_IDLE;
          wait_cnt_nxt = '0;
        end
      end
      ST_FORCE: begin
        cpu_drive    = 1'b1;
        state_nxt    = ST_IDLE;
        wait_cnt_nxt = '0;
      end
      default: begin
        state_nxt    = ST_IDLE;
        wait_cnt_nxt = '0;
      end
    endcase

    if (cpu_drive) begin
      bus.palette_mem_en  = 1'b1;
      bus.palette_mem_rw  = pend_we;
      bus.pal_addr        = pend_addr;
      bus.palette_data_in = pend_wdata;
    end else if (rend_own) begin
      bus.palette_mem_en  = 1'b1;
      bus.pal_addr        = bus.rend_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      wait_cnt       <= '0;
      pend_we        <= 1'b0;
      pend_addr      <= '0;
      pend_wdata     <= '0;
      last_color     <= '0;
      bus.rend_valid <= 1'b0;
      bus.rend_color <= '0;
      bus.rend_hold  <= 1'b0;
      bus.cpu_busy   <= 1'b0;
      bus.cpu_ack    <= 1'b0;
      bus.cpu_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (cpu_accept) begin
        pend_we    <= bus.cpu_we;
        pend_addr  <= bus.cpu_addr;
        pend_wdata <= bus.cpu_wdata;
      end
      bus.cpu_busy <= cpu_accept | (bus.cpu_busy & ~cpu_drive);
      bus.cpu_ack  <= cpu_drive;
      if (cpu_drive && !pend_we) bus.cpu_rdata <= bus.color_out;

      // A render request that coincides with a CPU-driven cycle can only be FORCE: repeat the last pixel.
      bus.rend_valid <= bus.rend_req;
      bus.rend_hold  <= bus.rend_req & cpu_drive;
      if (rend_own) begin
        bus.rend_color <= bus.color_out[5:0];
        last_color     <= bus.color_out[5:0];
      end else if (bus.rend_req) begin
        bus.rend_color <= last_color;
      end
    end
  end
endmodule

// File: tb/tb_ppu_palette_arbiter.sv
// Scoreboard bench for ppu_palette_arbiter with a behavioural palette RAM.
module tb_ppu_palette_arbiter;
  logic clk;
  logic rst_n;
  logic mem_load;
  logic mon_en;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  typedef struct { int cyc; logic [5:0] color; logic hold; } rend_exp_t;
  typedef struct { int cyc; logic [7:0] rdata; } cpu_exp_t;

  rend_exp_t rend_q[$];
  cpu_exp_t  cpu_q[$];
  rend_exp_t re;
  cpu_exp_t  ce;
  logic [7:0] mem [32];

  ppu_palette_arbiter_if bus();

  ppu_palette_arbiter #(.MAX_WAIT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] mir(input logic [4:0] a);
    return (a[4] && a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
  endfunction

  function automatic logic [7:0] mem_default(input int i);
    case (i)
      1:       return 8'h29;
      4:       return 8'h22;
      5:       return 8'hC7;
      default: return 8'h0F;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= mem_default(i);
    end else if (bus.palette_mem_en && bus.palette_mem_rw) begin
      mem[mir(bus.pal_addr)] <= bus.palette_data_in;
    end
  end

  assign bus.color_out = mem[mir(bus.pal_addr)];

  assert property (@(posedge clk) disable iff (!rst_n) !(bus.cpu_req && bus.cpu_busy))
    else $error("protocol violation: cpu_req while cpu_busy");

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rend_valid) begin
        if (rend_q.size() == 0) begin
          check("rend_unexpected", 32'd1, 32'd0);
        end else begin
          re = rend_q.pop_front();
          check("rend_cycle", cyc, re.cyc);
          check("rend_color", {26'd0, bus.rend_color}, {26'd0, re.color});
          check("rend_hold", {31'd0, bus.rend_hold}, {31'd0, re.hold});
        end
      end else if (rend_q.size() != 0 && rend_q[0].cyc <= cyc) begin
        re = rend_q.pop_front();
        check("rend_missing", 32'd0, 32'd1);
      end

      if (bus.cpu_ack) begin
        if (cpu_q.size() == 0) begin
          check("cpu_ack_unexpected", 32'd1, 32'd0);
        end else begin
          ce = cpu_q.pop_front();
          check("cpu_ack_cycle", cyc, ce.cyc);
          check("cpu_rdata", {24'd0, bus.cpu_rdata}, {24'd0, ce.rdata});
        end
      end else if (cpu_q.size() != 0 && cpu_q[0].cyc <= cyc) begin
        ce = cpu_q.pop_front();
        check("cpu_ack_missing", 32'd0, 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.cpu_req  = 1'b0;
    bus.rend_req = 1'b0;
  endtask

  task automatic rend(input logic [4:0] idx, input logic [5:0] color, input logic hold);
    bus.rend_req = 1'b1;
    bus.rend_idx = idx;
    rend_q.push_back('{cyc: cyc + 1, color: color, hold: hold});
  endtask

  task automatic cpu_op(input logic we, input logic [4:0] addr, input logic [7:0] wd,
                        input int ack_cyc, input logic [7:0] rdata);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    cpu_q.push_back('{cyc: ack_cyc, rdata: rdata});
  endtask

  int c;

  initial begin
    mon_en        = 1'b0;
    mem_load      = 1'b1;
    rst_n         = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 5'h1F;
    bus.cpu_wdata = 8'hFF;
    bus.rend_req  = 1'b1;
    bus.rend_idx  = 5'h01;

    // reset held two cycles with both requesters active
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_outs",
          {bus.rend_valid, bus.rend_hold, bus.rend_color, bus.cpu_busy, bus.cpu_ack, bus.cpu_rdata},
          32'd0);
    rst_n        = 1'b1;
    mem_load     = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.rend_req = 1'b0;
    mon_en       = 1'b1;
    tick(); tick();
    check("reset_busy", {31'd0, bus.cpu_busy}, 32'd0);

    // idle write, then render reads the new value
    c = cyc;
    cpu_op(1'b1, 5'h11, 8'h2A, c + 2, 8'h00);
    tick();
    #1;
    check("write_port", {17'd0, bus.palette_mem_en, bus.palette_mem_rw, bus.pal_addr, bus.palette_data_in},
          {17'd0, 1'b1, 1'b1, 5'h11, 8'h2A});
    check("write_busy", {31'd0, bus.cpu_busy}, 32'd1);
    tick();
    rend(5'h11, 6'h2A, 1'b0);
    tick(); tick();

    // idle read
    c = cyc;
    cpu_op(1'b0, 5'h04, 8'h00, c + 2, 8'h22);
    tick(); tick(); tick();

    // starvation: render every cycle, CPU forced at c+9
    c = cyc;
    for (int k = 0; k < 12; k++) begin
      if (k == 0) cpu_op(1'b1, 5'h02, 8'h35, c + 10, 8'h22);
      rend(5'h01, 6'h29, k == 9);
      if (k == 9) begin
        #1;
        check("force_port", {17'd0, bus.palette_mem_en, bus.palette_mem_rw, bus.pal_addr, bus.palette_data_in},
              {17'd0, 1'b1, 1'b1, 5'h02, 8'h35});
      end
      tick();
    end
    rend(5'h02, 6'h35, 1'b0);
    tick(); tick();

    // render gap: CPU read served in the first idle render cycle
    c = cyc;
    cpu_op(1'b0, 5'h05, 8'h00, c + 5, 8'hC7);
    tick();
    for (int k = 0; k < 3; k++) begin
      rend(5'h04, 6'h22, 1'b0);
      tick();
    end
    tick(); tick(); tick();

    // reset while a write is pending in WAIT
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 5'h03;
    bus.cpu_wdata = 8'h3A;
    tick();
    rend(5'h04, 6'h22, 1'b0);
    tick();
    rend(5'h04, 6'h22, 1'b0);
    tick();
    bus.rend_req = 1'b1;
    bus.rend_idx = 5'h04;
    rst_n        = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("midreset_busy", {31'd0, bus.cpu_busy}, 32'd0);
    tick(); tick(); tick();
    check("midreset_mem3", {24'd0, mem[3]}, 32'h0F);

    // operation resumes after reset; address 3 still holds its old value
    c = cyc;
    cpu_op(1'b0, 5'h03, 8'h00, c + 2, 8'h0F);
    tick(); tick(); tick();

    check("rend_q_empty", rend_q.size(), 32'd0);
    check("cpu_q_empty", cpu_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
